// File: rtl/mem_req_stage.sv
// EX-stage data-SRAM request issuer: encodes loads and stores into one SRAM transaction,
// raises address-error exceptions, and drops responses that belong to flushed requests.
module mem_req_stage #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_mem_valid,
  input  logic             es_mem_we,
  input  logic [6:0]       es_mem_op,
  input  logic [31:0]      es_addr,
  input  logic [31:0]      es_rt_value,
  input  logic             es_flush,
  output logic             es_mem_ready,
  output logic             es_adel,
  output logic             es_ades,
  output logic             data_sram_req,
  output logic             data_sram_wr,
  output logic [1:0]       data_sram_size,
  output logic [3:0]       data_sram_wstrb,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_addr_ok,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  output logic             ms_data_ok,
  output logic [31:0]      ms_rdata,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_cnt_out,
  output logic [CNT_W-1:0] dbg_cnt_cancel
);

  // Handshakes: the EX instruction (es_mem_valid + fields) is held until es_mem_ready or es_flush;
  // data_sram_req and all request fields are held until data_sram_addr_ok; data_ok is one response.

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic             cancel_q, cancel_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic [CNT_W-1:0] cnt_cancel_q, cnt_cancel_d;
  logic             wr_q;
  logic [1:0]       size_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      addr_q, wdata_q;

  logic        op_h, op_hu, op_b, op_bu, op_w, op_wr, op_wl;
  logic [1:0]  off;
  logic        adel_c, ades_c, exc_c;
  logic [1:0]  enc_size;
  logic [3:0]  enc_wstrb;
  logic [31:0] enc_addr, enc_wdata;
  logic        start, accept, cancel_now;

  assign {op_wl, op_wr, op_w, op_bu, op_b, op_hu, op_h} = es_mem_op;
  assign off = es_addr[1:0];

  assign adel_c = !es_mem_we && ((op_w && off != 2'd0) || ((op_h || op_hu) && off[0]));
  assign ades_c = es_mem_we && ((op_w && off != 2'd0) || (op_h && off[0]));
  assign exc_c  = adel_c || ades_c;

  always_comb begin
    enc_size  = 2'd2;
    enc_wstrb = 4'b0000;
    enc_wdata = 32'd0;
    enc_addr  = (op_wl || op_wr) ? {es_addr[31:2], 2'b00} : es_addr;
    if (op_b || op_bu) begin
      enc_size = 2'd0;
    end else if (op_h || op_hu) begin
      enc_size = 2'd1;
    end
    if (es_mem_we) begin
      if (op_b || op_bu) begin
        enc_wstrb = 4'b0001 << off;
        enc_wdata = {4{es_rt_value[7:0]}};
      end else if (op_h || op_hu) begin
        enc_wstrb = off[1] ? 4'b1100 : 4'b0011;
        enc_wdata = {2{es_rt_value[15:0]}};
      end else if (op_w) begin
        enc_wstrb = 4'b1111;
        enc_wdata = es_rt_value;
      end else if (op_wl) begin
        // Unaligned-left store: the register's upper bytes land in the low lanes.
        case (off)
          2'd0: begin enc_wstrb = 4'b0001; enc_wdata = {24'd0, es_rt_value[31:24]}; enc_size = 2'd0; end
          2'd1: begin enc_wstrb = 4'b0011; enc_wdata = {16'd0, es_rt_value[31:16]}; enc_size = 2'd1; end
          2'd2: begin enc_wstrb = 4'b0111; enc_wdata = {8'd0, es_rt_value[31:8]};   enc_size = 2'd2; end
          2'd3: begin enc_wstrb = 4'b1111; enc_wdata = es_rt_value;                 enc_size = 2'd2; end
        endcase
      end else if (op_wr) begin
        case (off)
          2'd0: begin enc_wstrb = 4'b1111; enc_wdata = es_rt_value;                 enc_size = 2'd2; end
          2'd1: begin enc_wstrb = 4'b1110; enc_wdata = {es_rt_value[23:0], 8'd0};   enc_size = 2'd2; end
          2'd2: begin enc_wstrb = 4'b1100; enc_wdata = {es_rt_value[15:0], 16'd0};  enc_size = 2'd1; end
          2'd3: begin enc_wstrb = 4'b1000; enc_wdata = {es_rt_value[7:0], 24'd0};   enc_size = 2'd0; end
        endcase
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cancel_d     = cancel_q;
    start        = 1'b0;
    es_mem_ready = 1'b0;
    es_adel      = 1'b0;
    es_ades      = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (es_mem_valid && !es_flush) begin
          if (exc_c) begin
            es_mem_ready = 1'b1;
            es_adel      = adel_c;
            es_ades      = ades_c;
          end else if (cnt_out_q < CNT_MAX) begin
            start   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (data_sram_addr_ok) begin
          state_d      = IDLE;
          cancel_d     = 1'b0;
          es_mem_ready = !(cancel_q || es_flush);
        end else if (es_flush) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = (state_q == REQ) && data_sram_addr_ok;
  assign cancel_now = accept && (cancel_q || es_flush);

  always_comb begin
    cnt_out_d = cnt_out_q;
    if (accept && !data_sram_data_ok) begin
      cnt_out_d = cnt_out_q + CNT_ONE;
    end else if (!accept && data_sram_data_ok) begin
      cnt_out_d = cnt_out_q - CNT_ONE;
    end
  end

  always_comb begin
    cnt_cancel_d = cnt_cancel_q;
    if (cancel_now && !(data_sram_data_ok && cnt_cancel_q != '0)) begin
      cnt_cancel_d = cnt_cancel_q + CNT_ONE;
    end else if (!cancel_now && data_sram_data_ok && cnt_cancel_q != '0) begin
      cnt_cancel_d = cnt_cancel_q - CNT_ONE;
    end
    // A flush orphans every transaction still in flight, including one accepted this cycle.
    if (es_flush) begin
      cnt_cancel_d = cnt_out_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cancel_q     <= 1'b0;
      cnt_out_q    <= '0;
      cnt_cancel_q <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wstrb_q      <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cancel_q     <= cancel_d;
      cnt_out_q    <= cnt_out_d;
      cnt_cancel_q <= cnt_cancel_d;
      if (start) begin
        wr_q    <= es_mem_we;
        size_q  <= enc_size;
        wstrb_q <= enc_wstrb;
        addr_q  <= enc_addr;
        wdata_q <= enc_wdata;
      end
    end
  end

  assign data_sram_req   = (state_q == REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;

  assign ms_data_ok = data_sram_data_ok && (cnt_cancel_q == '0);
  assign ms_rdata   = data_sram_rdata;

  assign dbg_state      = state_q;
  assign dbg_cnt_out    = cnt_out_q;
  assign dbg_cnt_cancel = cnt_cancel_q;

endmodule
